// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite responder backed by a word-addressed memory with OKAY/SLVERR decode.
// Define AXIL_SLV_STRB_EN to honour WSTRB byte lanes; otherwise full words are written.
module axi_lite_slave_mem #(
    parameter int unsigned                    C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                    C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]  C_S_BASE_ADDR      = 32'h40000000,
    parameter int unsigned                    C_S_MEM_DEPTH      = 1024
) (
    input  logic                             s00_axi_aclk,
    input  logic                             s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]    s00_axi_awaddr,
    input  logic [2:0]                       s00_axi_awprot,
    input  logic                             s00_axi_awvalid,
    output logic                             s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]    s00_axi_wdata,
    input  logic [3:0]                       s00_axi_wstrb,
    input  logic                             s00_axi_wvalid,
    output logic                             s00_axi_wready,
    output logic [1:0]                       s00_axi_bresp,
    output logic                             s00_axi_bvalid,
    input  logic                             s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]    s00_axi_araddr,
    input  logic [2:0]                       s00_axi_arprot,
    input  logic                             s00_axi_arvalid,
    output logic                             s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]    s00_axi_rdata,
    output logic [1:0]                       s00_axi_rresp,
    output logic                             s00_axi_rvalid,
    input  logic                             s00_axi_rready,
    output logic [31:0]                      wr_count,
    output logic [31:0]                      rd_count
);
    localparam int unsigned AW    = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned DW    = C_S_AXI_DATA_WIDTH;
    localparam int unsigned IDX_W = $clog2(C_S_MEM_DEPTH);
    localparam logic [AW-1:0] WINDOW = AW'(C_S_MEM_DEPTH * 4);

    typedef enum logic { W_IDLE, W_RESP } wstate_e;
    typedef enum logic { R_IDLE, R_RESP } rstate_e;

    logic [DW-1:0] mem [C_S_MEM_DEPTH];

    wstate_e       wstate_q, wstate_d;
    logic          aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          awready_q, awready_d, wready_q, wready_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic [31:0]   wr_count_q, wr_count_d;
    logic          mem_we;

    rstate_e       rstate_q, rstate_d;
    logic          arready_q, arready_d, rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [31:0]   rd_count_q, rd_count_d;

    // Decode uses the captured write address and the live read address
    logic [AW-1:0]    aw_off, ar_off;
    logic             aw_hit, ar_hit;
    logic [IDX_W-1:0] aw_idx, ar_idx;

    assign aw_off = awaddr_q - C_S_BASE_ADDR;
    assign ar_off = s00_axi_araddr - C_S_BASE_ADDR;
    assign aw_hit = (awaddr_q >= C_S_BASE_ADDR) && (aw_off < WINDOW);
    assign ar_hit = (s00_axi_araddr >= C_S_BASE_ADDR) && (ar_off < WINDOW);
    assign aw_idx = aw_off[IDX_W+1:2];
    assign ar_idx = ar_off[IDX_W+1:2];

`ifdef AXIL_SLV_STRB_EN
    logic [3:0] wstrb_q, wstrb_d;
    logic       unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, aw_off, ar_off};
`else
    logic       unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_wstrb, aw_off, ar_off};
`endif

    always_comb begin
        wstate_d   = wstate_q;
        aw_full_d  = aw_full_q;
        w_full_d   = w_full_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
`ifdef AXIL_SLV_STRB_EN
        wstrb_d    = wstrb_q;
`endif
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_count_d = wr_count_q;
        mem_we     = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (s00_axi_awvalid && awready_q) begin
                    aw_full_d = 1'b1;
                    awaddr_d  = s00_axi_awaddr;
                end
                if (s00_axi_wvalid && wready_q) begin
                    w_full_d = 1'b1;
                    wdata_d  = s00_axi_wdata;
`ifdef AXIL_SLV_STRB_EN
                    wstrb_d  = s00_axi_wstrb;
`endif
                end
                if (aw_full_q && w_full_q) begin
                    mem_we    = aw_hit && !s00_axi_areset;
                    bvalid_d  = 1'b1;
                    bresp_d   = aw_hit ? 2'b00 : 2'b10;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    wstate_d  = W_RESP;
                end
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    bvalid_d   = 1'b0;
                    bresp_d    = 2'b00;
                    wr_count_d = wr_count_q + 32'd1;
                    wstate_d   = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        awready_d = !aw_full_d && (wstate_d == W_IDLE);
        wready_d  = !w_full_d && (wstate_d == W_IDLE);
    end

    always_comb begin
        rstate_d   = rstate_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_count_d = rd_count_q;
        case (rstate_q)
            R_IDLE: begin
                if (s00_axi_arvalid && arready_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = ar_hit ? mem[ar_idx] : '0;
                    rresp_d  = ar_hit ? 2'b00 : 2'b10;
                    rstate_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s00_axi_rready) begin
                    rvalid_d   = 1'b0;
                    rd_count_d = rd_count_q + 32'd1;
                    rstate_d   = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (s00_axi_areset) begin
            wstate_q   <= W_IDLE;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
`ifdef AXIL_SLV_STRB_EN
            wstrb_q    <= '0;
`endif
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_count_q <= '0;
            rstate_q   <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            rd_count_q <= '0;
        end else begin
            wstate_q   <= wstate_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
`ifdef AXIL_SLV_STRB_EN
            wstrb_q    <= wstrb_d;
`endif
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_count_q <= wr_count_d;
            rstate_q   <= rstate_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_count_q <= rd_count_d;
        end
    end

    // Non-blocking write keeps a same-edge read on the old word
    always_ff @(posedge s00_axi_aclk) begin
        if (mem_we) begin
`ifdef AXIL_SLV_STRB_EN
            for (int b = 0; b < 4; b++)
                if (wstrb_q[b]) mem[aw_idx][8*b +: 8] <= wdata_q[8*b +: 8];
`else
            mem[aw_idx] <= wdata_q;
`endif
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = rresp_q;
    assign wr_count        = wr_count_q;
    assign rd_count        = rd_count_q;
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Directed bench for axi_lite_slave_mem with response scoreboard queues.
module tb_axi_lite_slave_mem;
    localparam logic [31:0] BASE  = 32'h40000000;
    localparam int          DEPTH = 1024;

    logic        s00_axi_aclk = 1'b0;
    logic        s00_axi_areset;
    logic [31:0] s00_axi_awaddr, s00_axi_araddr, s00_axi_wdata;
    logic [2:0]  s00_axi_awprot, s00_axi_arprot;
    logic        s00_axi_awvalid, s00_axi_awready, s00_axi_wvalid, s00_axi_wready;
    logic [3:0]  s00_axi_wstrb;
    logic [1:0]  s00_axi_bresp, s00_axi_rresp;
    logic        s00_axi_bvalid, s00_axi_bready, s00_axi_arvalid, s00_axi_arready;
    logic [31:0] s00_axi_rdata;
    logic        s00_axi_rvalid, s00_axi_rready;
    logic [31:0] wr_count, rd_count;

    axi_lite_slave_mem dut (
        .s00_axi_aclk(s00_axi_aclk), .s00_axi_areset(s00_axi_areset),
        .s00_axi_awaddr(s00_axi_awaddr), .s00_axi_awprot(s00_axi_awprot),
        .s00_axi_awvalid(s00_axi_awvalid), .s00_axi_awready(s00_axi_awready),
        .s00_axi_wdata(s00_axi_wdata), .s00_axi_wstrb(s00_axi_wstrb),
        .s00_axi_wvalid(s00_axi_wvalid), .s00_axi_wready(s00_axi_wready),
        .s00_axi_bresp(s00_axi_bresp), .s00_axi_bvalid(s00_axi_bvalid),
        .s00_axi_bready(s00_axi_bready), .s00_axi_araddr(s00_axi_araddr),
        .s00_axi_arprot(s00_axi_arprot), .s00_axi_arvalid(s00_axi_arvalid),
        .s00_axi_arready(s00_axi_arready), .s00_axi_rdata(s00_axi_rdata),
        .s00_axi_rresp(s00_axi_rresp), .s00_axi_rvalid(s00_axi_rvalid),
        .s00_axi_rready(s00_axi_rready), .wr_count(wr_count), .rd_count(rd_count)
    );

    always #5 s00_axi_aclk = ~s00_axi_aclk;

    typedef struct packed { logic [1:0] resp; logic [31:0] data; } exp_t;
    logic [1:0]  bq[$];
    exp_t        rq[$];
    logic [31:0] model [DEPTH];
    int checks = 0, errors = 0;
    int nwr = 0, nrd = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    endfunction

    function automatic int idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[11:2]);
    endfunction

    // Update the reference memory and return the expected BRESP
    function automatic logic [1:0] upd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (!in_rng(a)) return 2'b10;
`ifdef AXIL_SLV_STRB_EN
        for (int b = 0; b < 4; b++) if (s[b]) model[idx(a)][8*b +: 8] = d[8*b +: 8];
`else
        model[idx(a)] = d;
`endif
        return 2'b00;
    endfunction

    task automatic tick();
        @(posedge s00_axi_aclk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int g; bit aw_d, w_d, aw_n, w_n;
        bq.push_back(upd(a, d, s));
        s00_axi_awaddr = a; s00_axi_awvalid = 1'b1;
        s00_axi_wdata = d; s00_axi_wstrb = s; s00_axi_wvalid = 1'b1;
        s00_axi_bready = 1'b1;
        aw_d = 0; w_d = 0; g = 0;
        while (!(aw_d && w_d) && g < 50) begin
            aw_n = s00_axi_awvalid && s00_axi_awready;
            w_n  = s00_axi_wvalid && s00_axi_wready;
            tick(); g++;
            if (aw_n) begin aw_d = 1; s00_axi_awvalid = 1'b0; end
            if (w_n)  begin w_d = 1;  s00_axi_wvalid = 1'b0; end
        end
        chk("wr_hs_timeout", 32'(g >= 50), 0);
        g = 0;
        while (!s00_axi_bvalid && g < 50) begin tick(); g++; end
        chk("b_latency", g, 1);
        chk("bresp", {30'd0, s00_axi_bresp}, {30'd0, bq.pop_front()});
        tick(); nwr++;
        chk("bvalid_clr", {31'd0, s00_axi_bvalid}, 0);
        chk("wr_count", wr_count, nwr);
    endtask

    task automatic rd(input logic [31:0] a);
        int g; exp_t e;
        e.resp = in_rng(a) ? 2'b00 : 2'b10;
        e.data = in_rng(a) ? model[idx(a)] : 32'd0;
        rq.push_back(e);
        s00_axi_araddr = a; s00_axi_arvalid = 1'b1; s00_axi_rready = 1'b1;
        g = 0;
        while (!s00_axi_arready && g < 50) begin tick(); g++; end
        tick(); s00_axi_arvalid = 1'b0;
        chk("ar_timeout", 32'(g >= 50), 0);
        chk("r_latency", {31'd0, s00_axi_rvalid}, 1);
        e = rq.pop_front();
        chk("rdata", s00_axi_rdata, e.data);
        chk("rresp", {30'd0, s00_axi_rresp}, {30'd0, e.resp});
        tick(); nrd++;
        chk("rvalid_clr", {31'd0, s00_axi_rvalid}, 0);
        chk("rd_count", rd_count, nrd);
    endtask

    initial begin
        s00_axi_areset = 1'b1;
        s00_axi_awaddr = '0; s00_axi_awprot = '0; s00_axi_awvalid = 1'b0;
        s00_axi_wdata = '0; s00_axi_wstrb = 4'hF; s00_axi_wvalid = 1'b0;
        s00_axi_bready = 1'b0; s00_axi_araddr = '0; s00_axi_arprot = '0;
        s00_axi_arvalid = 1'b0; s00_axi_rready = 1'b0;

        // Reset: outputs all zero, READYs up after first released edge
        repeat (5) tick();
        chk("rst_ctrl", {23'd0, s00_axi_awready, s00_axi_wready, s00_axi_bvalid, s00_axi_bresp,
                         s00_axi_arready, s00_axi_rvalid, s00_axi_rresp}, 0);
        chk("rst_rdata", s00_axi_rdata, 0);
        chk("rst_cnt", wr_count | rd_count, 0);
        s00_axi_areset = 1'b0;
        tick();
        chk("rdy_after_rst", {29'd0, s00_axi_awready, s00_axi_wready, s00_axi_arready}, 32'd7);
        chk("cnt_after_rst", wr_count | rd_count, 0);

        // Aligned write/readback
        wr(32'h40000014, 32'hAA000005, 4'hF);
        rd(32'h40000014);

        // Skewed: W leads AW by 3 cycles, then B backpressure
        bq.push_back(upd(32'h40000020, 32'h5555AAAA, 4'hF));
        s00_axi_bready = 1'b0;
        s00_axi_wdata = 32'h5555AAAA; s00_axi_wstrb = 4'hF; s00_axi_wvalid = 1'b1;
        chk("wready_idle", {31'd0, s00_axi_wready}, 1);
        tick(); s00_axi_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("skew_wready_lo", {31'd0, s00_axi_wready}, 0);
            chk("skew_no_b", {31'd0, s00_axi_bvalid}, 0);
            if (i < 2) tick();
        end
        s00_axi_awaddr = 32'h40000020; s00_axi_awvalid = 1'b1;
        chk("awready_idle", {31'd0, s00_axi_awready}, 1);
        tick(); s00_axi_awvalid = 1'b0;
        chk("skew_b_early", {31'd0, s00_axi_bvalid}, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", {31'd0, s00_axi_bvalid}, 1);
            chk("bp_bresp", {30'd0, s00_axi_bresp}, {30'd0, bq[0]});
            chk("bp_readys", {30'd0, s00_axi_awready, s00_axi_wready}, 0);
            tick();
        end
        chk("bp_bvalid_hold", {31'd0, s00_axi_bvalid}, 1);
        s00_axi_bready = 1'b1;
        void'(bq.pop_front());
        tick(); nwr++;
        chk("bp_b_done", {31'd0, s00_axi_bvalid}, 0);
        chk("bp_wr_count", wr_count, nwr);
        chk("bp_readys_back", {30'd0, s00_axi_awready, s00_axi_wready}, 3);
        rd(32'h40000020);

        // Full sweep
        for (int i = 0; i < DEPTH; i++) wr(BASE + 32'(4 * i), 32'hAA000000 + 32'(i), 4'hF);
        for (int i = 0; i < DEPTH; i++) rd(BASE + 32'(4 * i));

        // Out-of-range: index 0 must survive an aliasing write
        wr(32'h40001000, 32'h12345678, 4'hF);
        rd(32'h40001000);
        rd(32'h3FFFFFFC);
        rd(32'h40000000);

        // Reset with only AW captured: no write, nothing pending
        s00_axi_awaddr = 32'h40000040; s00_axi_awvalid = 1'b1;
        tick(); s00_axi_awvalid = 1'b0;
        s00_axi_areset = 1'b1;
        tick();
        chk("rst_mid_bvalid", {31'd0, s00_axi_bvalid}, 0);
        chk("rst_mid_rdy", {29'd0, s00_axi_awready, s00_axi_wready, s00_axi_arready}, 0);
        s00_axi_areset = 1'b0;
        nwr = 0; nrd = 0;
        tick();
        chk("rst_mid_cnt", wr_count | rd_count, 0);
        s00_axi_wdata = 32'hDEADBEEF; s00_axi_wvalid = 1'b1;
        tick(); s00_axi_wvalid = 1'b0;
        repeat (3) begin
            chk("w_alone_no_b", {31'd0, s00_axi_bvalid}, 0);
            tick();
        end
        s00_axi_areset = 1'b1; tick(); s00_axi_areset = 1'b0; tick();
        rd(32'h40000040);

        // Byte strobes
        wr(32'h40000080, 32'hAA000000, 4'hF);
        wr(32'h40000080, 32'h12345678, 4'b0011);
        rd(32'h40000080);
        wr(32'h40000080, 32'hFFFFFFFF, 4'b0000);
        rd(32'h40000080);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
